// File: rtl/instruction_encoder_loader.sv
// Instruction encoder/loader: packs D/K/S/RAW instruction fields into 16-bit words
// and streams them into instruction memory at auto-incrementing addresses.
module instruction_encoder_loader #(
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int CHECK_FIELDS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [7:0]        in_op,
  input  logic [3:0]        in_s,
  input  logic              in_arp,
  input  logic [6:0]        in_d,
  input  logic [7:0]        in_k,
  input  logic [15:0]       in_raw,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WRITE = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                full_q, full_d;
  logic                pend_q, pend_d;
  logic                bad_start_s;
  logic                bad_field_s;

  function automatic logic [15:0] encode_word(
    input logic [1:0]  fmt,
    input logic [7:0]  op,
    input logic [3:0]  s,
    input logic        arp,
    input logic [6:0]  d,
    input logic [7:0]  k,
    input logic [15:0] raw
  );
    logic [15:0] w;
    case (fmt)
      2'd0:    w = {op, arp, d};
      2'd1:    w = {op, k};
      2'd2:    w = {op[3:0], s, k};
      default: w = raw;
    endcase
    return w;
  endfunction

  assign bad_start_s = ({1'b0, start_addr} >= DEPTH_C);
  assign bad_field_s = (CHECK_FIELDS != 0) && (in_fmt == 2'd2) && (in_op[7:4] != 4'd0);

  // State and datapath registers; reset clears every visible output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= 16'd0;
      count_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic for the load session.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    full_d  = full_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          pend_d  = 1'b0;
          full_d  = bad_start_s;
          err_d   = bad_start_s;
          if (bad_start_s) begin
            state_d = FULL;
          end else begin
            addr_d  = start_addr;
            state_d = READY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READY: begin
        if (in_valid) begin
          wdata_d = encode_word(in_fmt, in_op, in_s, in_arp, in_d, in_k, in_raw);
          err_d   = err_q | bad_field_s;
          pend_d  = finish;
          state_d = WRITE;
        end else if (finish) begin
          state_d = IDLE;
        end else begin
          state_d = READY;
        end
      end
      WRITE: begin
        pend_d = pend_q | finish;
        if (imem_ack) begin
          count_d = count_q + (ADDR_W+1)'(1);
          if (addr_q == LAST_C) begin
            full_d  = 1'b1;
            state_d = FULL;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            // A finish arriving on the ack cycle itself still closes the session.
            state_d = (pend_q || finish) ? IDLE : READY;
          end
        end else begin
          state_d = WRITE;
        end
      end
      FULL: begin
        if (finish) begin
          state_d = IDLE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready      = (state_q == READY);
  assign imem_we       = (state_q == WRITE);
  assign busy          = (state_q != IDLE);
  assign full          = full_q;
  assign err           = err_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign words_written = count_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Scoreboard bench for instruction_encoder_loader: expected {addr,data} pushed
// on accept, popped and compared by the memory responder on each write.
module tb_instruction_encoder_loader;
  localparam int AW = 4;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          finish;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_fmt;
  logic [7:0]    in_op;
  logic [3:0]    in_s;
  logic          in_arp;
  logic [6:0]    in_d;
  logic [7:0]    in_k;
  logic [15:0]   in_raw;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          imem_ack;
  logic          busy;
  logic          full;
  logic          err;
  logic [AW:0]   words_written;

  instruction_encoder_loader #(.ADDR_W(AW), .DEPTH(DP), .CHECK_FIELDS(1)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op), .in_s(in_s),
    .in_arp(in_arp), .in_d(in_d), .in_k(in_k), .in_raw(in_raw), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack), .busy(busy),
    .full(full), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW+15:0] sb[$];
  int  ack_delay = 0;
  int  wait_cnt  = 0;
  int  we_cnt    = 0;
  int  last_we   = 0;
  logic force_ack = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_delay cycles and checks each write against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
      we_cnt   = 0;
    end else if (imem_we) begin
      we_cnt++;
      check_eq("ready_low_in_write", {31'd0, in_ready}, 32'd0);
      check_eq("write_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() == 0) begin
        imem_ack = 1'b1;
      end else begin
        check_eq("wr_addr", {28'd0, imem_addr}, {28'd0, sb[0][AW+15:16]});
        check_eq("wr_data", {16'd0, imem_wdata}, {16'd0, sb[0][15:0]});
        if (wait_cnt >= ack_delay) begin
          imem_ack = 1'b1;
          void'(sb.pop_front());
          last_we  = we_cnt;
          we_cnt   = 0;
          wait_cnt = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end
    end else begin
      imem_ack = force_ack;
      wait_cnt = 0;
      we_cnt   = 0;
    end
  end

  task automatic start_session(input logic [AW-1:0] a);
    start = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_pulse();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic send(input logic [1:0] fmt, input logic [7:0] op, input logic [3:0] s,
                      input logic arp, input logic [6:0] d, input logic [7:0] k,
                      input logic [15:0] raw, input logic fin,
                      input logic [AW-1:0] exp_addr, input logic [15:0] exp_data);
    logic accepted;
    accepted = 1'b0;
    in_fmt = fmt; in_op = op; in_s = s; in_arp = arp; in_d = d; in_k = k; in_raw = raw;
    in_valid = 1'b1;
    finish = fin;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (in_ready) begin
        sb.push_back({exp_addr, exp_data});
        accepted = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish = 1'b0;
    check_eq("accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || imem_we) && i < 60) begin
      @(negedge clk);
      i++;
    end
    check_eq("drain_done", sb.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; finish = 1'b0; in_valid = 1'b0;
    in_fmt = 2'd0; in_op = 8'd0; in_s = 4'd0; in_arp = 1'b0; in_d = 7'd0; in_k = 8'd0;
    in_raw = 16'd0;
    #2;
    check_eq("rst_outputs", {in_ready, imem_we, busy, full, err}, 32'd0);
    check_eq("rst_addr_data", {12'd0, imem_addr, imem_wdata}, 32'd0);
    check_eq("rst_count", {27'd0, words_written}, 32'd0);
    #10 reset = 1'b0;
    @(negedge clk);

    // Basic D-type, immediate ack
    start_session(4'd0);
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    check_eq("ready_after_start", {31'd0, in_ready}, 32'd1);
    send(2'd0, 8'h20, 4'h0, 1'b1, 7'h05, 8'h00, 16'h0, 1'b0, 4'd0, 16'h2085);
    drain();
    check_eq("count_t1", {27'd0, words_written}, 32'd1);
    check_eq("err_t1", {31'd0, err}, 32'd0);

    // K then S back to back
    send(2'd1, 8'hA0, 4'h0, 1'b0, 7'h00, 8'h7F, 16'h0, 1'b0, 4'd1, 16'hA07F);
    send(2'd2, 8'h07, 4'h3, 1'b0, 7'h00, 8'h12, 16'h0, 1'b0, 4'd2, 16'h7312);
    drain();
    check_eq("count_t2", {27'd0, words_written}, 32'd3);

    // Delayed ack: write held 4 cycles, count +1
    ack_delay = 3;
    send(2'd3, 8'h00, 4'h0, 1'b0, 7'h00, 8'h00, 16'hBEEF, 1'b0, 4'd3, 16'hBEEF);
    drain();
    ack_delay = 0;
    check_eq("we_hold_cycles", last_we, 32'd4);
    check_eq("count_t3", {27'd0, words_written}, 32'd4);
    finish_pulse();
    check_eq("busy_after_finish", {31'd0, busy}, 32'd0);
    check_eq("count_hold_idle", {27'd0, words_written}, 32'd4);

    // Stray ack outside WRITE is ignored
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check_eq("stray_ack_count", {27'd0, words_written}, 32'd4);
    check_eq("stray_ack_busy", {31'd0, busy}, 32'd0);

    // Illegal S-type field: err set, word still written with op[3:0]
    start_session(4'd0);
    send(2'd2, 8'h17, 4'h0, 1'b0, 7'h00, 8'h00, 16'h0, 1'b0, 4'd0, 16'h7000);
    drain();
    check_eq("err_field", {31'd0, err}, 32'd1);
    finish_pulse();
    start_session(4'd0);
    check_eq("err_cleared", {31'd0, err}, 32'd0);
    finish_pulse();
    start_session(4'(DP));
    check_eq("err_bad_start", {31'd0, err}, 32'd1);
    check_eq("full_bad_start", {31'd0, full}, 32'd1);
    check_eq("ready_bad_start", {31'd0, in_ready}, 32'd0);
    finish_pulse();
    check_eq("busy_bad_start_fin", {31'd0, busy}, 32'd0);

    // Fill to the last address; third word must not be accepted
    start_session(4'(DP - 2));
    check_eq("full_cleared", {31'd0, full}, 32'd0);
    send(2'd1, 8'h01, 4'h0, 1'b0, 7'h00, 8'h11, 16'h0, 1'b0, 4'(DP - 2), 16'h0111);
    send(2'd1, 8'h02, 4'h0, 1'b0, 7'h00, 8'h22, 16'h0, 1'b0, 4'(DP - 1), 16'h0222);
    drain();
    check_eq("full_set", {31'd0, full}, 32'd1);
    check_eq("count_full", {27'd0, words_written}, 32'd2);
    in_valid = 1'b1; in_fmt = 2'd1; in_op = 8'h03; in_k = 8'h33;
    repeat (3) begin
      check_eq("ready_when_full", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("addr_no_wrap", {28'd0, imem_addr}, 32'(DP - 1));
    finish_pulse();
    check_eq("busy_full_fin", {31'd0, busy}, 32'd0);
    check_eq("full_hold", {31'd0, full}, 32'd1);

    // finish together with an accepted word
    start_session(4'd0);
    send(2'd0, 8'h01, 4'h0, 1'b0, 7'h7F, 8'h00, 16'h0, 1'b1, 4'd0, 16'h017F);
    drain();
    check_eq("busy_fin_pend", {31'd0, busy}, 32'd0);
    check_eq("count_fin_pend", {27'd0, words_written}, 32'd1);

    // Reset during WRITE drops everything asynchronously
    start_session(4'd0);
    ack_delay = 20;
    send(2'd1, 8'h55, 4'h0, 1'b0, 7'h00, 8'hAA, 16'h0, 1'b0, 4'd0, 16'h55AA);
    begin
      int i;
      i = 0;
      while (!imem_we && i < 10) begin
        @(negedge clk);
        i++;
      end
    end
    check_eq("we_before_reset", {31'd0, imem_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_outputs", {in_ready, imem_we, busy, full, err}, 32'd0);
    check_eq("rst_mid_addr_data", {12'd0, imem_addr, imem_wdata}, 32'd0);
    check_eq("rst_mid_count", {27'd0, words_written}, 32'd0);
    sb.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    check_eq("idle_after_reset", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
